// File: rtl/decryptor.sv
// -----------------------------------------------------------------------------
// decryptor -- iterative AES-128 inverse cipher, one round per clock.
//
// The key schedule is expanded forward into an 11-entry round-key store.
// The inverse rounds then consume that store from rk[10] down to rk[0].
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset (control and outputs only)
//   start      : request; sampled only while idle
//   ciphertext : 128-bit input block, byte 0 = bits [127:120], column-major
//   key        : 128-bit cipher key, same byte order
//   plaintext  : registered result, held until the next completion
//   done       : one-cycle pulse, plaintext valid from this cycle
//   busy       : high while an operation is in progress
//
// Also in this file:
//   aes_gf_pkg : GF(2^8) helpers shared by the byte substitution boxes
//   sbox       : forward S-box (multiplicative inverse + affine map)
//   inv_sbox   : inverse S-box (inverse affine map + multiplicative inverse)
// -----------------------------------------------------------------------------

package aes_gf_pkg;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0): 254 = 2+4+...+128,
    // so accumulate the successive squares a^2, a^4, ..., a^128.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// -----------------------------------------------------------------------------
// sbox -- forward AES S-box.
//   a : input byte
//   y : substituted byte
// -----------------------------------------------------------------------------
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_gf_pkg::*;

    logic [7:0] inv;

    assign inv = gf_inv(a);
    // Affine map: b ^ rotl(b,1) ^ rotl(b,2) ^ rotl(b,3) ^ rotl(b,4) ^ 0x63.
    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// -----------------------------------------------------------------------------
// inv_sbox -- inverse AES S-box.
//   a : input byte
//   y : substituted byte
// -----------------------------------------------------------------------------
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_gf_pkg::*;

    logic [7:0] t;

    // Inverse affine map: rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 0x05.
    assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y = gf_inv(t);
endmodule

// -----------------------------------------------------------------------------
// decryptor -- top level.
// -----------------------------------------------------------------------------
module decryptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plaintext,
    output logic         done,
    output logic         busy
);
    import aes_gf_pkg::*;

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} state_t;

    state_t       fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk [0:10];

    logic [127:0] rk_prev;
    logic [127:0] rk_cur;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  temp_w;
    logic [127:0] rk_next;
    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Column c occupies bits [127-32c -: 32]; row r within it is the r-th byte.
    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    // Round-key reads: rk_prev feeds the expansion step, rk_cur feeds the
    // inverse rounds. Indices outside the store read as zero and are never used.
    always_comb begin
        rk_prev = '0;
        rk_cur  = '0;
        for (int i = 0; i < 11; i++) begin
            if (cnt == 4'(i + 1)) rk_prev = rk[i];
            if (cnt == 4'(i))     rk_cur  = rk[i];
        end
    end

    // ---- key expansion step: rk[cnt] from rk[cnt-1] ----
    assign rot_w = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_ksub
        sbox u_sbox (
            .a (rot_w[31-8*g -: 8]),
            .y (sub_w[31-8*g -: 8])
        );
    end

    assign temp_w = sub_w ^ {rcon(cnt), 24'h000000};

    always_comb begin
        rk_next[127:96] = rk_prev[127:96] ^ temp_w;
        rk_next[95:64]  = rk_prev[95:64]  ^ rk_next[127:96];
        rk_next[63:32]  = rk_prev[63:32]  ^ rk_next[95:64];
        rk_next[31:0]   = rk_prev[31:0]   ^ rk_next[63:32];
    end

    // ---- inverse round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey ----
    // Row r rotates right by r: output column c takes row r from column c-r.
    always_comb begin
        isr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127-32*c-8*r -: 8] = st[127-32*((c-r+4)%4)-8*r -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_isub
        inv_sbox u_inv_sbox (
            .a (isr[127-8*g -: 8]),
            .y (isb[127-8*g -: 8])
        );
    end

    // In FINAL the counter has reached 0, so this is the rk[0] whitening.
    assign ark = isb ^ rk_cur;

    // ---- control and outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            cnt       <= 4'd0;
            plaintext <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        cnt  <= 4'd1;
                        busy <= 1'b1;
                        fsm  <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10) fsm <= INIT;
                end
                INIT: begin
                    cnt <= 4'd9;
                    fsm <= ROUND;
                end
                ROUND: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    plaintext <= ark;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cnt       <= 4'd0;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // ---- state and key store (not reset; only meaningful while busy) ----
    always_ff @(posedge clk) begin
        case (fsm)
            IDLE: begin
                if (start && !rst) begin
                    st    <= ciphertext;
                    rk[0] <= key;
                end
            end
            KEYEXP: begin
                for (int i = 1; i < 11; i++) begin
                    if (cnt == 4'(i)) rk[i] <= rk_next;
                end
            end
            INIT:    st <= st ^ rk[10];
            ROUND:   st <= inv_mix(ark);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decryptor.sv
// -----------------------------------------------------------------------------
// tb_decryptor -- self-checking bench for the iterative AES-128 decryptor.
// Directed FIPS-197 vectors, back-to-back starts, ignored starts, reset
// abort, and a randomized round-trip against a byte-array AES-128 encryption
// model held in the bench.
// -----------------------------------------------------------------------------
module tb_decryptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always #5 clk = ~clk;

    decryptor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .plaintext  (plaintext),
        .done       (done),
        .busy       (busy)
    );

    // GF(2^8) product: carry-less multiply, then polynomial long division by 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    // S-box table: brute-force inverse search, then the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] y;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int z = 1; z < 256; z++) if (gm(8'(x), 8'(z)) == 8'h01) inv = 8'(z);
            for (int i = 0; i < 8; i++)
                y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = y;
        end
    endtask

    // Reference AES-128 forward cipher on byte arrays.
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   tmp [16];
        logic [7:0]   t [4];
        logic [7:0]   t0, rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0   = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[t0];
                rc   = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r+4*c] = s[r+4*((c+r)%4)];
            for (int i = 0; i < 16; i++) s[i] = tmp[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the start is sampled at the next rising edge (E0)
    // and the task returns at the falling edge just after E0. Inputs are then
    // scrambled so any late sampling would corrupt the result.
    task automatic pulse_start(input logic [127:0] k, input logic [127:0] c);
        start      = 1'b1;
        key        = k;
        ciphertext = c;
        @(negedge clk);
        start      = 1'b0;
        key        = rand128();
        ciphertext = rand128();
    endtask

    // Counts falling edges until done is seen; n = k when done follows edge Ek.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
    endtask

    // Full operation from start to the done cycle; returns in the done cycle.
    task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                          input logic [127:0] exp, input logic [127:0] prev);
        int n;
        pulse_start(k, c);
        chk({tag, "_busy_hi"}, 128'(busy), 128'(1));
        chk({tag, "_pt_hold"}, plaintext, prev);
        wait_done(n);
        chk({tag, "_latency"}, 128'(n), 128'(21));
        chk({tag, "_pt"}, plaintext, exp);
        chk({tag, "_busy_lo"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int n;
        int nd;
        logic [127:0] rk_r, pt_r, ct_r, prev;

        rst        = 1'b1;
        start      = 1'b0;
        key        = '0;
        ciphertext = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        chk("rst_pt", plaintext, '0);
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1, then confirm done lasts exactly one cycle.
        run_op("c1", C1_KEY, C1_CT, C1_PT, '0);
        @(negedge clk);
        chk("c1_done_single", 128'(done), 128'(0));

        // FIPS-197 Appendix B.
        run_op("fipsb", B_KEY, B_CT, B_PT, C1_PT);
        @(negedge clk);

        // All-zero key, then C.1 started in the done cycle (22 cycles between dones).
        run_op("zero", '0, Z_CT, '0, B_PT);
        run_op("b2b_c1", C1_KEY, C1_CT, C1_PT, '0);

        // Randomized round-trip, each started in the previous done cycle.
        prev = C1_PT;
        for (int t = 0; t < 16; t++) begin
            rk_r = rand128();
            pt_r = rand128();
            ct_r = aes_enc(rk_r, pt_r);
            run_op($sformatf("rt%0d", t), rk_r, ct_r, pt_r, prev);
            prev = pt_r;
        end
        @(negedge clk);

        // A second start during an operation is ignored.
        pulse_start(B_KEY, B_CT);
        repeat (4) @(negedge clk);
        pulse_start(rand128(), rand128());
        wait_done(n);
        chk("ign_latency", 128'(n), 128'(16));
        chk("ign_pt", plaintext, B_PT);
        count_dones(30, nd);
        chk("ign_no_extra_done", 128'(nd), 128'(0));
        chk("ign_busy_lo", 128'(busy), 128'(0));

        // Reset at cycle 12 of an operation aborts it.
        pulse_start(C1_KEY, C1_CT);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_pt", plaintext, '0);
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        count_dones(30, nd);
        chk("abort_no_done", 128'(nd), 128'(0));
        run_op("after_abort", B_KEY, B_CT, B_PT, '0);
        @(negedge clk);

        // Reset and start on the same edge: reset wins.
        rst        = 1'b1;
        start      = 1'b1;
        key        = C1_KEY;
        ciphertext = C1_CT;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 128'(busy), 128'(0));
        count_dones(30, nd);
        chk("rst_start_no_done", 128'(nd), 128'(0));
        chk("rst_start_pt", plaintext, '0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
